// File: rtl/spi_master_cmd_seq_pkg.sv
// Shared types and constants for the SPI command sequencer.
// FSM encodings and the FIFO entry layout {want_rx, tx_data}.
package spi_master_cmd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_END  = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ENTRY_W    = DEF_DATA_WIDTH + 1;

  function automatic int unsigned entry_w(input int unsigned dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Single-clock command FIFO with occupancy output.
// Depth must be a power of two so the pointers wrap naturally.
module spi_cmd_fifo #(
  parameter  int W     = 17,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/spi_master_cmd_seq.sv
// Queues host SPI commands and sequences them into an SPI master,
// returning received words when the command asked for them.
module spi_master_cmd_seq
  import spi_master_cmd_seq_pkg::*;
#(
  parameter  int DATA_WIDTH     = 16,
  parameter  int CMD_FIFO_DEPTH = 4,
  localparam int LW             = $clog2(CMD_FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_tx_data,
  input  logic                  cmd_want_rx,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  spi_begin,
  output logic [DATA_WIDTH-1:0] spi_master_tx_data,
  input  logic                  spi_is_busy,
  input  logic                  spi_end,
  input  logic [DATA_WIDTH-1:0] spi_master_rx_data,
  input  logic                  spi_master_rx_data_valid,
  output logic [LW-1:0]         cmd_level,
  output logic                  seq_busy
);

  localparam int EW = entry_w(DATA_WIDTH);

  seq_state_e            r_state;
  seq_state_e            w_next;
  logic [DATA_WIDTH-1:0] r_tx;
  logic                  r_want;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [EW-1:0]         w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_launch_ok;
  logic                  w_rx_take;

  spi_cmd_fifo #(
    .W     (EW),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_din   ({cmd_want_rx, cmd_tx_data}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_level (cmd_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cmd_ready = ~w_full;
  assign w_push    = cmd_valid & cmd_ready;

  // A want_rx command may only launch once the response slot is free.
  assign w_launch_ok = ~w_empty & ~spi_is_busy
                     & (~w_head[DATA_WIDTH] | ~r_rsp_valid);

  assign w_rx_take = spi_master_rx_data_valid & r_want
                   & ((r_state == WAIT_BUSY) | (r_state == WAIT_END));

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_launch_ok) begin
          w_next = LAUNCH;
          w_pop  = 1'b1;
        end
      end
      LAUNCH:    w_next = WAIT_BUSY;
      WAIT_BUSY: if (spi_is_busy) w_next = WAIT_END;
      WAIT_END:  if (spi_end) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_tx        <= '0;
      r_want      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_tx   <= w_head[DATA_WIDTH-1:0];
        r_want <= w_head[DATA_WIDTH];
      end
      if (r_rsp_valid) begin
        if (rsp_ready) r_rsp_valid <= 1'b0;
      end else if (w_rx_take) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= spi_master_rx_data;
      end
    end
  end

  assign spi_begin          = (r_state == LAUNCH);
  assign spi_master_tx_data = r_tx;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_data           = r_rsp_data;
  assign seq_busy           = (r_state != IDLE) | (cmd_level != '0);

endmodule

// File: tb/tb_spi_master_cmd_seq.sv
// Directed bench for spi_master_cmd_seq with a simple SPI master model.
// The model answers each spi_begin with busy, an rx pulse and spi_end.
module tb_spi_master_cmd_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_tx_data = '0;
  logic        cmd_want_rx = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        spi_begin;
  logic [15:0] spi_master_tx_data;
  logic        spi_is_busy;
  logic        spi_end = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [2:0]  cmd_level;
  logic        seq_busy;

  logic        m_busy = 1'b0;
  logic        force_busy = 1'b0;
  bit          m_active = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_rx_word = '0;
  logic [15:0] tx_log [$];
  int          n_begin = 0;
  int          n_overlap = 0;
  bit          rsp_seen = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign spi_is_busy = m_busy | force_busy;

  spi_master_cmd_seq dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .cmd_valid                (cmd_valid),
    .cmd_ready                (cmd_ready),
    .cmd_tx_data              (cmd_tx_data),
    .cmd_want_rx              (cmd_want_rx),
    .rsp_valid                (rsp_valid),
    .rsp_ready                (rsp_ready),
    .rsp_data                 (rsp_data),
    .spi_begin                (spi_begin),
    .spi_master_tx_data       (spi_master_tx_data),
    .spi_is_busy              (spi_is_busy),
    .spi_end                  (spi_end),
    .spi_master_rx_data       (rx_data),
    .spi_master_rx_data_valid (rx_valid),
    .cmd_level                (cmd_level),
    .seq_busy                 (seq_busy)
  );

  always @(negedge clk) begin
    spi_end  = 1'b0;
    rx_valid = 1'b0;
    if (rsp_valid) rsp_seen = 1'b1;
    if (!rstn) begin
      m_active = 1'b0;
      m_busy   = 1'b0;
    end else if (spi_begin) begin
      if (m_active) n_overlap++;
      n_begin++;
      tx_log.push_back(spi_master_tx_data);
      m_active = 1'b1;
      m_cnt    = 0;
      m_busy   = 1'b1;
    end else if (m_active) begin
      m_cnt++;
      if (m_cnt == 4) begin
        rx_valid = 1'b1;
        rx_data  = m_rx_word;
      end
      if (m_cnt == 5) begin
        spi_end  = 1'b1;
        m_busy   = 1'b0;
        m_active = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [15:0] d, input logic w,
                      output bit acc);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_tx_data = d;
    cmd_want_rx = w;
    acc         = cmd_ready;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!seq_busy && !m_busy) break;
    end
    chk(tag, {31'd0, seq_busy}, 32'd0);
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic chk_log(input string tag, input int idx,
                         input logic [15:0] exp);
    logic [15:0] v;
    v = (idx < tx_log.size()) ? tx_log[idx] : 16'hxxxx;
    chk($sformatf("%s%0d", tag, idx), {16'd0, v}, {16'd0, exp});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    bit seen;

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_level", {29'd0, cmd_level}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rspd", {16'd0, rsp_data}, 32'd0);
    chk("rst_tx", {16'd0, spi_master_tx_data}, 32'd0);
    chk("rst_begin", {31'd0, spi_begin}, 32'd0);
    chk("rst_busy", {31'd0, seq_busy}, 32'd0);

    // single want_rx command, latency and response
    m_rx_word = 16'h3C3C;
    push(16'hA55A, 1'b1, acc);
    chk("t1_acc", {31'd0, acc}, 32'd1);
    @(negedge clk);
    chk("t1_lat_n1", {31'd0, spi_begin}, 32'd0);
    @(negedge clk);
    chk("t1_lat_n2", {31'd0, spi_begin}, 32'd1);
    chk("t1_tx", {16'd0, spi_master_tx_data}, 32'h0000A55A);
    wait_rsp("t1_rspv");
    chk("t1_rspd", {16'd0, rsp_data}, 32'h00003C3C);
    chk("t1_nbegin", n_begin, 32'd1);
    @(negedge clk) rsp_ready = 1'b1;
    @(negedge clk) rsp_ready = 1'b0;
    chk("t1_rsp_clr", {31'd0, rsp_valid}, 32'd0);
    wait_idle("t1_idle");

    // fill the FIFO while the master is busy, fifth push held
    n_begin = 0;
    tx_log.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(16'h0011 + 16'(i), 1'b0, acc);
      chk($sformatf("t2_acc%0d", i), {31'd0, acc}, (i < 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("t2_ready", {31'd0, cmd_ready}, 32'd0);
    chk("t2_level", {29'd0, cmd_level}, 32'd4);
    cmd_valid   = 1'b1;
    cmd_tx_data = 16'h0015;
    cmd_want_rx = 1'b0;
    force_busy  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t2_ready_again", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle("t2_idle");
    chk("t2_nbegin", n_begin, 32'd5);
    for (int i = 0; i < 5; i++) chk_log("t2_tx", i, 16'h0011 + 16'(i));

    // response back-pressure stalls the second want_rx command
    n_begin = 0;
    tx_log.delete();
    m_rx_word = 16'h7777;
    push(16'h1111, 1'b1, acc);
    push(16'h2222, 1'b1, acc);
    repeat (30) @(negedge clk);
    chk("t3_nbegin1", n_begin, 32'd1);
    chk("t3_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("t3_rspd", {16'd0, rsp_data}, 32'h00007777);
    chk("t3_level", {29'd0, cmd_level}, 32'd1);
    m_rx_word = 16'h8888;
    rsp_ready = 1'b1;
    @(negedge clk) rsp_ready = 1'b0;
    wait_rsp("t3_rspv2");
    chk("t3_rspd2", {16'd0, rsp_data}, 32'h00008888);
    chk("t3_nbegin2", n_begin, 32'd2);
    chk_log("t3_tx", 1, 16'h2222);
    rsp_ready = 1'b1;
    @(negedge clk) rsp_ready = 1'b0;
    wait_idle("t3_idle");

    // three fire-and-forget commands in order
    n_begin = 0;
    n_overlap = 0;
    tx_log.delete();
    rsp_seen = 1'b0;
    push(16'h0001, 1'b0, acc);
    push(16'h0002, 1'b0, acc);
    push(16'h0003, 1'b0, acc);
    wait_idle("t4_idle");
    chk("t4_nbegin", n_begin, 32'd3);
    for (int i = 0; i < 3; i++) chk_log("t4_tx", i, 16'(i + 1));
    chk("t4_rsp_seen", {31'd0, rsp_seen}, 32'd0);
    chk("t4_overlap", n_overlap, 32'd0);

    // simultaneous push and pop at level 2
    n_begin = 0;
    tx_log.delete();
    force_busy = 1'b1;
    push(16'h0A0A, 1'b0, acc);
    push(16'h0B0B, 1'b0, acc);
    @(negedge clk);
    chk("t5_level2", {29'd0, cmd_level}, 32'd2);
    cmd_valid   = 1'b1;
    cmd_tx_data = 16'h0C0C;
    cmd_want_rx = 1'b0;
    force_busy  = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_level_same", {29'd0, cmd_level}, 32'd2);
    chk("t5_begin", {31'd0, spi_begin}, 32'd1);
    wait_idle("t5_idle");
    chk("t5_nbegin", n_begin, 32'd3);
    chk_log("t5_tx", 0, 16'h0A0A);
    chk_log("t5_tx", 1, 16'h0B0B);
    chk_log("t5_tx", 2, 16'h0C0C);

    // reset in WAIT_END with three commands queued
    n_begin = 0;
    tx_log.delete();
    push(16'hD001, 1'b1, acc);
    push(16'hD002, 1'b1, acc);
    push(16'hD003, 1'b1, acc);
    push(16'hD004, 1'b1, acc);
    chk("t6_level_pre", {29'd0, cmd_level}, 32'd3);
    chk("t6_nbegin_pre", n_begin, 32'd1);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("t6_level", {29'd0, cmd_level}, 32'd0);
    chk("t6_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("t6_ready", {31'd0, cmd_ready}, 32'd1);
    chk("t6_tx", {16'd0, spi_master_tx_data}, 32'd0);
    repeat (20) @(negedge clk);
    chk("t6_nbegin_post", n_begin, 32'd1);
    chk("t6_busy", {31'd0, seq_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master_cmd_seq.md
SPI_MASTER_CMD_SEQ -- requirements
Module: spi_master_cmd_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, SPI word width; equals the downstream SPI master's DATA_WIDTH, minimum 2.
REQ-002 SHALL have parameter CMD_FIFO_DEPTH, default 4, command FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  block clock, shared with the SPI master.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  host command offered.
REQ-006 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-007 SHALL have port cmd_tx_data  input  DATA_WIDTH  word to transmit, MSB first.
REQ-008 SHALL have port cmd_want_rx  input  1  return the received word to the host.
REQ-009 SHALL have port rsp_valid  output  1  response word held.
REQ-010 SHALL have port rsp_ready  input  1  host takes the response.
REQ-011 SHALL have port rsp_data  output  DATA_WIDTH  received word.
REQ-012 SHALL have port spi_begin  output  1  start pulse to the SPI master.
REQ-013 SHALL have port spi_master_tx_data  output  DATA_WIDTH  word to the SPI master.
REQ-014 SHALL have port spi_is_busy  input  1  SPI master busy.
REQ-015 SHALL have port spi_end  input  1  SPI master transfer-complete pulse.
REQ-016 SHALL have port spi_master_rx_data  input  DATA_WIDTH  SPI master receive word.
REQ-017 SHALL have port spi_master_rx_data_valid  input  1  receive word valid pulse.
REQ-018 SHALL have port cmd_level  output  clog2(CMD_FIFO_DEPTH)+1  FIFO occupancy.
REQ-019 SHALL have port seq_busy  output  1  high when the state is not IDLE or cmd_level is non-zero.

Function
REQ-020 Command push occurs on cmd_valid && cmd_ready; cmd_ready = (cmd_level != CMD_FIFO_DEPTH), no combinational path from cmd_valid.
REQ-021 FIFO stores {cmd_want_rx, cmd_tx_data}; a same-cycle push and pop leaves cmd_level unchanged; a push while full is ignored.
REQ-022 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_END.
REQ-023 IDLE->LAUNCH when FIFO non-empty, spi_is_busy low, and (head want_rx=0 or rsp_valid=0); on this transition the head is popped, its data loaded into spi_master_tx_data, and want_rx latched.
REQ-024 spi_begin SHALL be high exactly for the single LAUNCH cycle; LAUNCH->WAIT_BUSY unconditionally.
REQ-025 WAIT_BUSY->WAIT_END on spi_is_busy high.
REQ-026 WAIT_END->IDLE on spi_end.
REQ-027 spi_master_tx_data SHALL hold its value from LAUNCH until the next LAUNCH.
REQ-028 When spi_master_rx_data_valid is high in WAIT_BUSY or WAIT_END and want_rx is latched, rsp_data SHALL load spi_master_rx_data and rsp_valid SHALL set on the next edge; rx pulses with want_rx=0 or in other states are ignored.
REQ-029 rsp_valid SHALL clear on rsp_valid && rsp_ready; rsp_data is held stable while rsp_valid is high.
REQ-030 Latency: a command pushed into an empty FIFO at edge N with the block idle SHALL produce spi_begin in cycle N+2.
REQ-031 Back-to-back: the next LAUNCH occurs no earlier than the cycle after spi_end, and only once spi_is_busy is low.
REQ-032 A pending want_rx command SHALL stall in IDLE while rsp_valid=1; want_rx=0 commands proceed regardless of rsp_valid.

Reset
REQ-033 On rstn low at a clk edge: state=IDLE, FIFO empty, cmd_level=0, cmd_ready=1 after reset release, spi_begin=0, spi_master_tx_data=0, rsp_valid=0, rsp_data=0, want_rx latch=0.
REQ-034 Reset mid-transfer SHALL discard all queued commands and any pending response; no spi_begin SHALL be issued until a new command arrives.

Structure
REQ-035 A shared package SHALL hold the FSM state encodings and the FIFO entry width constant (DATA_WIDTH+1).
REQ-036 The FIFO SHALL be a sub-module, spi_cmd_fifo: synchronous, single clock, with a level output.
REQ-037 The FSM, tx register and response register SHALL reside in the top module.

Verification
REQ-038 Push 0xA55A with want_rx=1, model master returns 0x3C3C -> one spi_begin with tx 0xA55A at cycle N+2, then rsp_valid with rsp_data 0x3C3C.
REQ-039 Push 5 commands with depth 4 and no SPI progress -> cmd_ready low after 4, level=4, fifth held until a pop.
REQ-040 Two want_rx commands, rsp_ready held low -> second spi_begin withheld until the first response is consumed.
REQ-041 Three want_rx=0 commands 0x0001/0x0002/0x0003 -> three ordered spi_begin pulses, each after the prior spi_end, rsp_valid never set.
REQ-042 Simultaneous push and pop at level 2 -> level stays 2 and order is preserved.
REQ-043 rstn low during WAIT_END with 3 queued -> level 0, rsp_valid 0, no further spi_begin.
